// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache for the MEM stage.
// Misses freeze the pipeline and are resolved with line-wide req/ack transfers.
module dcache_ctrl #(
    parameter int unsigned LINES      = 32,
    parameter int unsigned LINE_BYTES = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr_i,
    input  logic [31:0]             wdata_i,
    input  logic [1:0]              width_i,
    input  logic                    sign_ext_i,
    input  logic                    read_i,
    input  logic                    write_i,
    output logic [31:0]             rdata_o,
    output logic                    mem_stall_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [31:0]             mem_addr_o,
    output logic [8*LINE_BYTES-1:0] mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [8*LINE_BYTES-1:0] mem_rdata_i
);

    localparam int unsigned IW  = $clog2(LINES);
    localparam int unsigned OW  = $clog2(LINE_BYTES);
    localparam int unsigned TW  = 32 - IW - OW;
    localparam int unsigned LW  = 8 * LINE_BYTES;
    localparam int unsigned BPW = OW + 3;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;

    state_t          r_state, w_state_n;
    logic            r_req;
    logic [LINES-1:0] r_valid, r_dirty;
    logic [TW-1:0]   r_tag  [LINES];
    logic [LW-1:0]   r_data [LINES];

    logic [TW-1:0]   w_tag;
    logic [IW-1:0]   w_idx;
    logic [BPW-1:0]  w_bitpos;
    logic [LW-1:0]   w_line;
    logic [31:0]     w_word;
    logic            w_req, w_hit, w_ack, w_fill_done, w_store;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wval, w_mask, w_merged;

    // Address split; w_bitpos is the bit offset of the addressed word in the line
    assign w_tag    = addr_i[31:IW+OW];
    assign w_idx    = addr_i[IW+OW-1:OW];
    assign w_bitpos = {addr_i[OW-1:0], 3'b000} & ~BPW'(31);
    assign w_line   = r_data[w_idx];
    assign w_word   = w_line[w_bitpos +: 32];

    assign w_req       = read_i | write_i;
    assign w_hit       = w_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_ack       = mem_ack_i && r_req;
    assign w_fill_done = (r_state == S_FILL) && w_ack;
    assign w_store     = (r_state == S_IDLE) && write_i && w_hit;

    // Load lane extraction and extension
    assign w_byte = w_word[{addr_i[1:0], 3'b000} +: 8];
    assign w_half = w_word[{addr_i[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_word;
        case (width_i)
            2'd0:    w_load = {{24{sign_ext_i & w_byte[7]}}, w_byte};
            2'd1:    w_load = {{16{sign_ext_i & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    assign rdata_o = (read_i && !write_i && w_hit) ? w_load : 32'h0;

    // Store lane placement and byte-enable merge
    always_comb begin
        w_be   = 4'b1111;
        w_wval = wdata_i;
        case (width_i)
            2'd0: begin
                w_be   = 4'b0001 << addr_i[1:0];
                w_wval = {4{wdata_i[7:0]}};
            end
            2'd1: begin
                w_be   = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wval = {2{wdata_i[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wval = wdata_i;
            end
        endcase
    end

    assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_merged = (w_word & ~w_mask) | (w_wval & w_mask);

    // Next-state and memory-side outputs
    always_comb begin
        w_state_n   = r_state;
        mem_stall_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_req_o   = r_req;
        mem_addr_o  = {w_tag, w_idx, OW'(0)};
        mem_wdata_o = w_line;
        case (r_state)
            S_IDLE: begin
                if (w_req && !w_hit) begin
                    mem_stall_o = 1'b1;
                    w_state_n   = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_FILL;
                end
            end
            S_WB: begin
                mem_stall_o = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {r_tag[w_idx], w_idx, OW'(0)};
                if (w_ack) w_state_n = S_FILL;
            end
            S_FILL: begin
                mem_stall_o = 1'b1;
                if (w_ack) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Control state; req rises one cycle after leaving IDLE and holds across WB->FILL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_n;
            r_req   <= (r_state != S_IDLE) && !w_fill_done;
            if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_store) begin
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx] <= mem_rdata_i;
            r_tag[w_idx]  <= w_tag;
        end else if (w_store) begin
            r_data[w_idx][w_bitpos +: 32] <= w_merged;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a small backing-memory responder.
module tb_dcache_ctrl;

    logic         clk, rst_n;
    logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o;
    logic [1:0]   width_i;
    logic         sign_ext_i, read_i, write_i;
    logic         mem_stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [255:0] mem_wdata_o, mem_rdata_i;

    int vecs = 0;
    int errs = 0;

    int          stall_n;
    logic        saw_wb, saw_fill, timed_out;
    logic [31:0] wb_addr, wb_word0, fill_addr, got_rdata;
    logic [255:0] bmem [logic [31:0]];

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .wdata_i(wdata_i),
        .width_i(width_i), .sign_ext_i(sign_ext_i), .read_i(read_i),
        .write_i(write_i), .rdata_o(rdata_o), .mem_stall_o(mem_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Untouched lines hold their own word addresses; line 0x100 word 0 is 0xDEADBEEF
    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = a + 32'(4 * k);
        if (a == 32'h100) p[31:0] = 32'hDEADBEEF;
        return p;
    endfunction

    // One access; acks the d-th request cycle of each transaction, ends in the hit cycle
    task automatic access(input logic [31:0] a, input logic [1:0] w, input logic se,
                          input logic rd, input logic wr, input logic [31:0] wd,
                          input int d_wb, input int d_fill);
        int wb_n, fill_n;
        @(negedge clk);
        addr_i = a; width_i = w; sign_ext_i = se; read_i = rd; write_i = wr; wdata_i = wd;
        stall_n = 0; saw_wb = 0; saw_fill = 0; timed_out = 0; wb_n = 0; fill_n = 0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (!mem_stall_o) begin
                got_rdata = rdata_o;
                return;
            end
            stall_n++;
            if (mem_req_o) begin
                if (mem_we_o) begin
                    if (wb_n == 0) begin
                        saw_wb = 1; wb_addr = mem_addr_o; wb_word0 = mem_wdata_o[31:0];
                    end
                    if (wb_n == d_wb) begin
                        mem_ack_i = 1'b1;
                        bmem[mem_addr_o] = mem_wdata_o;
                    end
                    wb_n++;
                end else begin
                    if (fill_n == 0) begin
                        saw_fill = 1; fill_addr = mem_addr_o;
                    end
                    if (fill_n == d_fill) begin
                        mem_ack_i   = 1'b1;
                        mem_rdata_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : pat(mem_addr_o);
                    end
                    fill_n++;
                end
            end
            @(negedge clk);
            mem_ack_i = 1'b0;
        end
        timed_out = 1;
        $display("FAIL access_timeout: addr %h still stalled after 64 cycles", a);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL rst_stall: got %b want 0", mem_stall_o); end
        vecs++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
        vecs++; if (mem_we_o !== 1'b0) begin errs++; $display("FAIL rst_we: got %b want 0", mem_we_o); end
        addr_i = 32'h100; read_i = 1'b1; width_i = 2'd2;
        #1;
        vecs++; if (rdata_o !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 00000000", rdata_o); end
        vecs++; if (mem_stall_o !== 1'b1) begin errs++; $display("FAIL rst_miss_stall: got %b want 1", mem_stall_o); end
        read_i = 1'b0;
    endtask

    task automatic test_cold_read;
        access(32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (stall_n !== 3) begin errs++; $display("FAIL cold_stall: got %0d want 3", stall_n); end
        vecs++; if (saw_wb !== 1'b0) begin errs++; $display("FAIL cold_no_wb: got %b want 0", saw_wb); end
        vecs++; if (fill_addr !== 32'h100) begin errs++; $display("FAIL cold_fill_addr: got %h want 00000100", fill_addr); end
        vecs++; if (got_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL cold_rdata: got %h want deadbeef", got_rdata); end
    endtask

    task automatic test_narrow_loads;
        logic [31:0] a [5]  = '{32'h103, 32'h102, 32'h100, 32'h100, 32'h103};
        logic [1:0]  w [5]  = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd1};
        logic        s [5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] e [5]  = '{32'hFFFFFFDE, 32'h0000DEAD, 32'h000000EF, 32'hFFFFBEEF, 32'h0000DEAD};
        for (int i = 0; i < 5; i++) begin
            access(a[i], w[i], s[i], 1'b1, 1'b0, 32'h0, 0, 0);
            vecs++; if (stall_n !== 0) begin errs++; $display("FAIL narrow_stall[%0d]: got %0d want 0", i, stall_n); end
            vecs++; if (got_rdata !== e[i]) begin errs++; $display("FAIL narrow_rdata[%0d]: got %h want %h", i, got_rdata, e[i]); end
        end
    endtask

    task automatic test_store_hit;
        access(32'h101, 2'd0, 1'b0, 1'b0, 1'b1, 32'h00000055, 0, 0);
        vecs++; if (stall_n !== 0) begin errs++; $display("FAIL sb_stall: got %0d want 0", stall_n); end
        access(32'h106, 2'd1, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 0, 0);
        access(32'h10B, 2'd3, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 0, 0);
        access(32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (got_rdata !== 32'hDEAD55EF) begin errs++; $display("FAIL sb_rdata: got %h want dead55ef", got_rdata); end
        access(32'h104, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (got_rdata !== 32'h12340104) begin errs++; $display("FAIL sh_rdata: got %h want 12340104", got_rdata); end
        access(32'h108, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (got_rdata !== 32'hCAFEF00D) begin errs++; $display("FAIL sw3_rdata: got %h want cafef00d", got_rdata); end
    endtask

    task automatic test_dirty_evict;
        access(32'h500, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 1, 0);
        vecs++; if (saw_wb !== 1'b1) begin errs++; $display("FAIL evict_wb_seen: got %b want 1", saw_wb); end
        vecs++; if (wb_addr !== 32'h100) begin errs++; $display("FAIL evict_wb_addr: got %h want 00000100", wb_addr); end
        vecs++; if (wb_word0 !== 32'hDEAD55EF) begin errs++; $display("FAIL evict_wb_data: got %h want dead55ef", wb_word0); end
        vecs++; if (fill_addr !== 32'h500) begin errs++; $display("FAIL evict_fill_addr: got %h want 00000500", fill_addr); end
        vecs++; if (stall_n !== 5) begin errs++; $display("FAIL evict_stall: got %0d want 5", stall_n); end
        vecs++; if (got_rdata !== 32'h00000500) begin errs++; $display("FAIL evict_rdata: got %h want 00000500", got_rdata); end
        access(32'h100, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (saw_wb !== 1'b0) begin errs++; $display("FAIL refill_no_wb: got %b want 0", saw_wb); end
        vecs++; if (got_rdata !== 32'hDEAD55EF) begin errs++; $display("FAIL refill_rdata: got %h want dead55ef", got_rdata); end
    endtask

    task automatic test_ack_sweep;
        logic [31:0] a [3] = '{32'h1000, 32'h2020, 32'h3040};
        int          d [3] = '{0, 1, 5};
        int          e [3] = '{3, 4, 8};
        for (int i = 0; i < 3; i++) begin
            access(a[i], 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, d[i]);
            vecs++; if (stall_n !== e[i]) begin errs++; $display("FAIL sweep_stall[%0d]: got %0d want %0d", i, stall_n, e[i]); end
            vecs++; if (saw_wb !== 1'b0) begin errs++; $display("FAIL sweep_no_wb[%0d]: got %b want 0", i, saw_wb); end
            vecs++; if (got_rdata !== a[i]) begin errs++; $display("FAIL sweep_rdata[%0d]: got %h want %h", i, got_rdata, a[i]); end
        end
    endtask

    task automatic test_reset_mid_fill;
        logic seen;
        seen = 0;
        @(negedge clk);
        addr_i = 32'h700; width_i = 2'd2; read_i = 1'b1; write_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_req_o) begin seen = 1; break; end
            @(negedge clk);
        end
        vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL midfill_req_rise: got %b want 1", seen); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        vecs++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL midfill_req_drop: got %b want 0", mem_req_o); end
        vecs++; if (mem_we_o !== 1'b0) begin errs++; $display("FAIL midfill_we: got %b want 0", mem_we_o); end
        rst_n = 1'b1; read_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = pat(32'h700);
        @(negedge clk);
        mem_ack_i = 1'b0;
        #1;
        vecs++; if (mem_req_o !== 1'b0) begin errs++; $display("FAIL stray_ack_req: got %b want 0", mem_req_o); end
        vecs++; if (mem_stall_o !== 1'b0) begin errs++; $display("FAIL stray_ack_stall: got %b want 0", mem_stall_o); end
        access(32'h700, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0);
        vecs++; if (saw_fill !== 1'b1) begin errs++; $display("FAIL reread_fill: got %b want 1", saw_fill); end
        vecs++; if (stall_n !== 3) begin errs++; $display("FAIL reread_stall: got %0d want 3", stall_n); end
        vecs++; if (got_rdata !== 32'h00000700) begin errs++; $display("FAIL reread_rdata: got %h want 00000700", got_rdata); end
    endtask

    initial begin
        rst_n = 1'b0; addr_i = '0; wdata_i = '0; width_i = '0; sign_ext_i = 1'b0;
        read_i = 1'b0; write_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
        test_reset();
        test_cold_read();
        test_narrow_loads();
        test_store_hit();
        test_dirty_evict();
        test_ack_sweep();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
